bin_window_gen: RTL and testbench

- Upstream feeder for the XNOR-popcount multiplier stage.
- Converts a raster stream of 1-bit binarised pixels, one pixel per accepted beat, into 7x7 sliding windows.
- Each window is a 49-bit vector that drives the multiplier's `img` input.
- Uses six line buffers plus a 7x7 window register, with a valid/ready handshake on both sides.

---
 rtl/bin_pkg.sv | 9 +
 rtl/bin_window_gen_if.sv | 25 ++
 rtl/bin_line_buf.sv | 17 +
 rtl/bin_window_gen.sv | 82 ++++++++
 tb/tb_bin_window_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_pkg.sv
// bin_pkg: window geometry shared by the window generator and the XNOR-popcount multiplier.
package bin_pkg;
    localparam int WIN_K = 7;
    localparam int WIN_BITS = WIN_K * WIN_K;
    typedef logic [WIN_BITS-1:0] win_t;
    function automatic int win_idx(input int r, input int c);
        return WIN_K * r + c;
    endfunction
endpackage

// File: rtl/bin_window_gen_if.sv
// bin_window_gen_if: pixel-in / window-out handshake bundle; BIN_WINDOW_STATUS_EN adds frame_done and win_count.
interface bin_window_gen_if;
    import bin_pkg::*;
    logic pix_in;
    logic pix_valid;
    logic pix_sof;
    logic pix_ready;
    win_t win_out;
    logic win_valid;
    logic win_ready;
    logic win_last;
`ifdef BIN_WINDOW_STATUS_EN
    logic frame_done;
    logic [15:0] win_count;
    modport master (output pix_in, pix_valid, pix_sof, win_ready,
                    input pix_ready, win_out, win_valid, win_last, frame_done, win_count);
    modport slave (input pix_in, pix_valid, pix_sof, win_ready,
                   output pix_ready, win_out, win_valid, win_last, frame_done, win_count);
`else
    modport master (output pix_in, pix_valid, pix_sof, win_ready,
                    input pix_ready, win_out, win_valid, win_last);
    modport slave (input pix_in, pix_valid, pix_sof, win_ready,
                   output pix_ready, win_out, win_valid, win_last);
`endif
endinterface

// File: rtl/bin_line_buf.sv
// bin_line_buf: 1-bit shift register, DEPTH deep, advancing only when en is high.
module bin_line_buf #(
    parameter int DEPTH = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else if (en) sr <= {sr[DEPTH-2:0], d};
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/bin_window_gen.sv
// bin_window_gen: raster 1-bit pixel stream to 7x7 sliding windows for the XNOR-popcount stage.
// Defining BIN_WINDOW_STATUS_EN adds frame_done and a saturating consumed-window count.
module bin_window_gen
    import bin_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CW = 8
) (
    input logic clk,
    input logic rst,
    bin_window_gen_if.slave bus
);
    logic [CW-1:0] row, col, rc, cc;
    logic acc, emit, last, cons, valid, last_q;
    logic [WIN_K-1:0] chain;
    win_t win, win_nxt;
    assign bus.pix_ready = !valid || bus.win_ready;
    assign acc = bus.pix_valid && bus.pix_ready;
    assign cons = valid && bus.win_ready;
    assign rc = bus.pix_sof ? '0 : row;
    assign cc = bus.pix_sof ? '0 : col;
    assign emit = acc && rc >= CW'(WIN_K - 1) && cc >= CW'(WIN_K - 1);
    assign last = rc == CW'(IMG_H - 1) && cc == CW'(IMG_W - 1);
    // chain[k] is the pixel k rows above the incoming one, same column
    assign chain[0] = bus.pix_in;
    for (genvar k = 0; k < WIN_K - 1; k++) begin : g_lb
        bin_line_buf #(.DEPTH(IMG_W)) u_lb (
            .clk(clk),
            .rst(rst),
            .en(acc),
            .d(chain[k]),
            .q(chain[k+1])
        );
    end
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K - 1; c++) win_nxt[win_idx(r, c)] = win[win_idx(r, c + 1)];
            win_nxt[win_idx(r, WIN_K - 1)] = chain[WIN_K - 1 - r];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            win <= '0;
            valid <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (acc) begin
                win <= win_nxt;
                col <= cc == CW'(IMG_W - 1) ? '0 : cc + CW'(1);
                row <= cc != CW'(IMG_W - 1) ? rc : rc == CW'(IMG_H - 1) ? '0 : rc + CW'(1);
            end
            if (emit) begin
                valid <= 1'b1;
                last_q <= last;
            end else if (cons) begin
                valid <= 1'b0;
            end
        end
    end
    assign bus.win_out = win;
    assign bus.win_valid = valid;
    assign bus.win_last = last_q;
`ifdef BIN_WINDOW_STATUS_EN
    logic done;
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            cnt <= '0;
        end else begin
            done <= cons && last_q;
            if (cons && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
    end
    assign bus.frame_done = done;
    assign bus.win_count = cnt;
`endif
endmodule

// File: tb/tb_bin_window_gen.sv
// tb_bin_window_gen: directed frames checked against a 7x7 patch-extraction model of the accepted pixel stream.
module tb_bin_window_gen;
    import bin_pkg::*;
    localparam int W = 8;
    localparam int H = 8;
    localparam win_t ONES = 49'h1_FFFF_FFFF_FFFF;
    localparam win_t ODD = 49'h0_AAAA_AAAA_AAAA;
    localparam win_t EVEN = 49'h1_5555_5555_5555;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    bin_window_gen_if bus();
    bin_window_gen #(.IMG_W(W), .IMG_H(H), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    logic frm [H][W];
    logic img [H][W];
    int mr = 0, mc = 0, ar, ac;
    win_t exp_q[$];
    logic exp_l[$];
    win_t log_w[$];
    logic log_l[$];
    win_t ref_w[$];
    win_t cb[4] = '{ODD, EVEN, EVEN, ODD};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // window whose bottom-right pixel is (r,c), read straight out of the frame image
    function automatic win_t patch(input int r, input int c);
        win_t w;
        for (int i = 0; i < WIN_K; i++)
            for (int j = 0; j < WIN_K; j++) w[WIN_K * i + j] = img[r - 6 + i][c - 6 + j];
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_l.delete();
            mr = 0;
            mc = 0;
        end else begin
            chk("pix_ready", 64'(bus.pix_ready), 64'(!bus.win_valid || bus.win_ready));
            if (bus.win_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_window: got %h expected no window", bus.win_out);
                end else begin
                    chk("win_out", 64'(bus.win_out), 64'(exp_q[0]));
                    chk("win_last", 64'(bus.win_last), 64'(exp_l[0]));
                end
                if (bus.win_ready) begin
                    log_w.push_back(bus.win_out);
                    log_l.push_back(bus.win_last);
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                ar = bus.pix_sof ? 0 : mr;
                ac = bus.pix_sof ? 0 : mc;
                img[ar][ac] = bus.pix_in;
                if (ar >= 6 && ac >= 6) begin
                    exp_q.push_back(patch(ar, ac));
                    exp_l.push_back(ar == H - 1 && ac == W - 1);
                end
                mr = ar;
                mc = ac + 1;
                if (mc == W) begin
                    mc = 0;
                    mr = (ar + 1) % H;
                end
            end
        end
    end

    task automatic send(input logic p, input logic sof);
        int n = 0;
        bus.pix_in = p;
        bus.pix_sof = sof;
        bus.pix_valid = 1;
        @(negedge clk);
        while (!bus.pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pix_ready) fail("send");
        @(posedge clk);
        #1;
        bus.pix_valid = 0;
        bus.pix_sof = 0;
    endtask

    task automatic send_frame(input int npix, input int gap, input bit sof);
        for (int k = 0; k < npix; k++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                @(posedge clk);
                #1;
            end
            send(frm[k / W][k % W], sof && k == 0);
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic stall_ctrl();
        int n = 0;
        win_t held;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.win_valid && n < 500);
        if (!bus.win_valid) fail("stall_wait");
        held = bus.win_out;
        repeat (10) begin
            @(negedge clk);
            chk("stall_pix_ready", 64'(bus.pix_ready), 64'(0));
            chk("stall_hold", 64'(bus.win_out), 64'(held));
        end
        @(posedge clk);
        #1;
        bus.win_ready = 1;
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frm[r][c] = mode == 0 ? 1'b1 : mode == 1 ? logic'((r + c) % 2) : logic'($urandom_range(1));
    endtask

    initial begin
        bus.pix_in = 0;
        bus.pix_valid = 0;
        bus.pix_sof = 0;
        bus.win_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_valid", 64'(bus.win_valid), 64'(0));
        chk("rst_last", 64'(bus.win_last), 64'(0));
        chk("rst_out", 64'(bus.win_out), 64'(0));
        // all-ones frame
        fill(0);
        log_w.delete();
        log_l.delete();
        send_frame(64, 0, 1);
        drain();
        chk("ones_count", 64'(log_w.size()), 64'(4));
        for (int i = 0; i < log_w.size(); i++) begin
            chk("ones_win", 64'(log_w[i]), 64'(ONES));
            chk("ones_last", 64'(log_l[i]), 64'(i == 3));
        end
        // checkerboard
        fill(1);
        log_w.delete();
        log_l.delete();
        send_frame(64, 0, 1);
        drain();
        chk("cb_count", 64'(log_w.size()), 64'(4));
        for (int i = 0; i < log_w.size(); i++) chk("cb_win", 64'(log_w[i]), 64'(cb[i]));
        if (log_w.size() > 0) begin
            chk("cb_bit0", 64'(log_w[0][0]), 64'(0));
            chk("cb_bit1", 64'(log_w[0][1]), 64'(1));
        end
        // backpressure: same random frame unstalled, then stalled
        fill(2);
        log_w.delete();
        log_l.delete();
        send_frame(64, 0, 1);
        drain();
        ref_w = log_w;
        log_w.delete();
        log_l.delete();
        bus.win_ready = 0;
        fork
            send_frame(64, 0, 1);
            stall_ctrl();
        join
        drain();
        chk("bp_count", 64'(log_w.size()), 64'(ref_w.size()));
        for (int i = 0; i < log_w.size() && i < ref_w.size(); i++) chk("bp_seq", 64'(log_w[i]), 64'(ref_w[i]));
        // random frame with valid gaps
        fill(2);
        log_w.delete();
        log_l.delete();
        send_frame(64, 50, 1);
        drain();
        chk("gap_count", 64'(log_w.size()), 64'(4));
        // partial all-ones frame abandoned at row 3, then a checkerboard frame restarts via sof
        fill(0);
        log_w.delete();
        log_l.delete();
        send_frame(8 * 3 + 3, 0, 1);
        fill(1);
        send_frame(64, 0, 1);
        drain();
        chk("sof_count", 64'(log_w.size()), 64'(4));
        if (log_w.size() > 0) chk("sof_first", 64'(log_w[0]), 64'(ODD));
        // reset with a stalled window pending, then a frame without sof
        fill(0);
        bus.win_ready = 0;
        for (int k = 0; k < 6 * W + 7; k++) send(1'b1, k == 0);
        rst = 1;
        bus.pix_valid = 1;
        bus.pix_in = 0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.win_valid), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus.win_valid), 64'(0));
        chk("mid_rst_out", 64'(bus.win_out), 64'(0));
        chk("mid_rst_last", 64'(bus.win_last), 64'(0));
        @(posedge clk);
        #1;
        rst = 0;
        bus.pix_valid = 0;
        bus.win_ready = 1;
        fill(1);
        log_w.delete();
        log_l.delete();
        send_frame(64, 0, 0);
        drain();
        chk("post_rst_count", 64'(log_w.size()), 64'(4));
        if (log_w.size() == 4) chk("post_rst_last", 64'(log_l[3]), 64'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
